// File: rtl/uart_bram_frame_ctrl.sv
// UART <-> BRAM frame sequencer: buffers one frame of received bytes as
// 16-bit words, then echoes the frame back to the transmitter.
module uart_bram_frame_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int FRAME_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [15:0]       dina,
    output logic [ADDR_W-1:0] addrb,
    input  logic [15:0]       doutb,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        RX_LO,
        RX_HI,
        WR,
        RD_ADDR,
        RD_WAIT,
        TX_LO,
        TX_HI,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        lo_byte;
    logic [15:0]       word_reg;
    logic              seen_busy;
    logic              tx_ready;
    logic              playback;

    assign tx_ready = !tx_busy && !tx_start;
    assign playback = (state == RD_ADDR) || (state == RD_WAIT) ||
                      (state == TX_LO)   || (state == TX_HI)   ||
                      (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_LO;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lo_byte    <= '0;
            word_reg   <= '0;
            seen_busy  <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            addrb      <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wea        <= 1'b0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            if (rx_valid && playback)
                overrun <= 1'b1;
            unique case (state)
                RX_LO: begin
                    if (rx_valid) begin
                        lo_byte <= rx_data;
                        state   <= RX_HI;
                    end
                end
                RX_HI: begin
                    if (rx_valid) begin
                        dina  <= {rx_data, lo_byte};
                        addra <= wr_ptr;
                        wea   <= 1'b1;
                        state <= WR;
                    end
                end
                WR: begin
                    if (wr_ptr == LAST) begin
                        // Frame full: a byte landing here has no slot.
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        addrb  <= '0;
                        state  <= RD_ADDR;
                        if (rx_valid)
                            overrun <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (rx_valid) begin
                            lo_byte <= rx_data;
                            state   <= RX_HI;
                        end else begin
                            state <= RX_LO;
                        end
                    end
                end
                RD_ADDR: begin
                    addrb <= rd_ptr;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    // addrb was already presented during RD_ADDR
                    word_reg <= doutb;
                    state    <= TX_LO;
                end
                TX_LO: begin
                    if (tx_ready) begin
                        tx_data   <= word_reg[7:0];
                        tx_start  <= 1'b1;
                        seen_busy <= 1'b0;
                        state     <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (tx_busy)
                        seen_busy <= 1'b1;
                    if (tx_ready && seen_busy) begin
                        tx_data  <= word_reg[15:8];
                        tx_start <= 1'b1;
                        if (rd_ptr == LAST) begin
                            state <= DONE;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                            addrb  <= rd_ptr + 1'b1;
                            state  <= RD_ADDR;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    state      <= RX_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bram_frame_ctrl.sv
// Bench for uart_bram_frame_ctrl: BRAM and UART-tx models, frame-level
// reference built from the byte stream, table-driven plus hand sequences.
module tb_uart_bram_frame_ctrl;

    localparam int AW = 12;
    localparam int FW = 4;
    localparam int NB = 2 * FW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          tx_busy = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          wea;
    logic [AW-1:0] addra;
    logic [15:0]   dina;
    logic [AW-1:0] addrb;
    logic [15:0]   doutb = '0;
    logic          frame_done;
    logic          overrun;

    uart_bram_frame_ctrl #(.ADDR_W(AW), .FRAME_WORDS(FW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .wea(wea), .addra(addra), .dina(dina), .addrb(addrb),
        .doutb(doutb), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle-latency BRAM, seeded with junk so stale reads are visible
    logic [15:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hDEAD;
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        doutb <= mem[addrb];
    end

    // Transmitter: busy rises the cycle after tx_start, lasts busy_len cycles
    int busy_len = 3;
    int bcnt = 0;
    always @(posedge clk) begin
        if (tx_start && !tx_busy) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len - 1;
        end else if (tx_busy) begin
            if (bcnt == 0) tx_busy <= 1'b0;
            else bcnt <= bcnt - 1;
        end
    end

    logic [AW-1:0] wr_a_q[$];
    logic [15:0]   wr_d_q[$];
    logic [7:0]    tx_q[$];
    int            tx_c_q[$];
    int            fd_q[$];
    int            viol = 0;
    logic [7:0]    held = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wea) begin
                wr_a_q.push_back(addra);
                wr_d_q.push_back(dina);
            end
            if (tx_start) begin
                tx_q.push_back(tx_data);
                tx_c_q.push_back(cyc);
                held = tx_data;
                if (tx_busy) viol++;
            end else if (tx_busy && tx_data != held) begin
                viol++;
            end
            if (frame_done) fd_q.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wr_a_q.delete();
        wr_d_q.delete();
        tx_q.delete();
        tx_c_q.delete();
        fd_q.delete();
        viol = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        clear_logs();
    endtask

    logic [7:0] bytes [NB];

    task automatic send(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            rx_data  = bytes[i];
            rx_valid = 1'b1;
            @(negedge clk);
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic inject_byte();
        int k;
        k = 0;
        while (tx_q.size() < 2 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("inject_wait", int'(tx_q.size() >= 2), 1);
        repeat (3) @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        while (fd_q.size() == 0 && k < 4000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("frame_done_seen", int'(fd_q.size() > 0), 1);
        repeat (40) @(negedge clk);
    endtask

    // Reference: words are byte pairs little-endian at 0..FW-1; the echo
    // is the received byte stream in order; done one cycle after last start.
    task automatic check_frame(input string tag, input bit exp_ovr);
        chk({tag, "_wr_count"}, wr_a_q.size(), FW);
        for (int i = 0; i < FW; i++) begin
            if (i < wr_a_q.size()) begin
                chk($sformatf("%s_addra%0d", tag, i), wr_a_q[i], i);
                chk($sformatf("%s_dina%0d", tag, i), wr_d_q[i],
                    {bytes[2*i+1], bytes[2*i]});
            end
        end
        chk({tag, "_tx_count"}, tx_q.size(), NB);
        for (int i = 0; i < NB; i++)
            if (i < tx_q.size())
                chk($sformatf("%s_tx%0d", tag, i), tx_q[i], bytes[i]);
        chk({tag, "_done_count"}, fd_q.size(), 1);
        if (fd_q.size() > 0 && tx_c_q.size() > 0)
            chk({tag, "_done_lat"}, fd_q[0] - tx_c_q[tx_c_q.size()-1], 1);
        chk({tag, "_tx_protocol"}, viol, 0);
        chk({tag, "_overrun"}, overrun, exp_ovr);
    endtask

    typedef struct {
        int         mode;    // 0 sequential, 1 random, 2 BEEF then random
        logic [7:0] base;
        int         gap;
        int         busy;
        bit         do_rst;
        bit         inject;
        bit         exp_ovr;
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{0, 8'h01, 2, 3,  1'b1, 1'b0, 1'b0};
        vt[1] = '{2, 8'h00, 1, 5,  1'b0, 1'b0, 1'b0};
        vt[2] = '{0, 8'h30, 0, 20, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1, 8'h00, 1, 20, 1'b0, 1'b1, 1'b1};
        vt[4] = '{0, 8'h80, 0, 4,  1'b0, 1'b0, 1'b1};
        vt[5] = '{1, 8'h00, 3, 2,  1'b1, 1'b0, 1'b0};
        for (int i = 6; i < 10; i++)
            vt[i] = '{1, 8'h00, int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 25)), 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int v = 0; v < 10; v++) begin
            if (vt[v].do_rst) do_reset();
            clear_logs();
            busy_len = vt[v].busy;
            for (int i = 0; i < NB; i++) begin
                case (vt[v].mode)
                    0:       bytes[i] = vt[v].base + 8'(i);
                    default: bytes[i] = 8'($urandom_range(0, 255));
                endcase
            end
            if (vt[v].mode == 2) begin
                bytes[0] = 8'hEF;
                bytes[1] = 8'hBE;
            end
            send(NB, vt[v].gap);
            if (vt[v].inject) inject_byte();
            wait_frame();
            check_frame($sformatf("vec%0d", v), vt[v].exp_ovr);
        end

        // Reset in the middle of a fill drops the partial frame
        do_reset();
        busy_len = 6;
        bytes[0] = 8'hAA;
        bytes[1] = 8'hBB;
        bytes[2] = 8'hCC;
        send(3, 1);
        do_reset();
        for (int i = 0; i < NB; i++) bytes[i] = 8'h11 + 8'(i);
        send(NB, 1);
        wait_frame();
        if (wr_d_q.size() > 0) chk("midrst_first_dina", wr_d_q[0], 16'h1211);
        check_frame("midrst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
